truth_table_sweeper: RTL



---
 rtl/truth_table_sweeper.sv | 124 ++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Drives the four 2-input vectors (ab = 00, 10, 01, 11) into an external gate,
// captures its output at the end of each hold window and compares the table.
module truth_table_sweeper #(
    parameter int         HOLD_CYCLES = 4,       // 1..255
    parameter logic [3:0] EXPECTED    = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic       match
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       truth_q, truth_d;
    logic             match_q, match_d;

    always_comb begin
        // NOTE: every next-state value starts from a default so no path leaves it unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        truth_d = truth_q;
        match_d = match_q;

        unique case (state_q)
            IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    truth_d = 4'b0000;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    truth_d[idx_q] = c;
                    if (idx_q != 2'd3) begin
                        // The next vector goes out on the same edge that samples this one.
                        idx_d      = idx_q + 2'd1;
                        {b_d, a_d} = idx_q + 2'd1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = ({c, truth_q[2:0]} == EXPECTED);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            truth_q <= 4'b0000;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            truth_q <= truth_d;
            match_q <= match_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign truth = truth_q;
    assign match = match_q;

endmodule
